core_status_responder: RTL

- Core-side counterpart of the clock/flush controller. It consumes the two-phase strobes (phase1/phase2) and the decoded instruction stream, then drives the halted and flush_detected requests back to the controller.
- Tracks halt, resume and branch-flush conditions.
- Provides retired-instruction and flush counters for debug.
- Fully synchronous to internal_clock; no internal delays.

---
 rtl/core_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/core_status_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core status responder: state encoding and opcode defaults.
package core_pkg;

    localparam int OP_W = 8;
    localparam logic [OP_W-1:0] HLT_OPCODE_DEF = 8'hFF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/core_status_responder.sv
// Core-side responder to the clock/flush controller: tracks halt, resume and
// branch-flush conditions from the phase strobes and keeps debug counters.
//
// state  | meaning
// RUN    | capturing on phase1, retiring on phase2
// FLUSH  | branch taken; discarding captures until FLUSH_CYCLES phase2 strobes pass
// HALTED | HLT retired; waiting for resume
module core_status_responder
    import core_pkg::*;
#(
    parameter logic [OP_W-1:0] HLT_OPCODE   = HLT_OPCODE_DEF,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 8
) (
    input  logic             internal_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             phase1,
    input  logic             phase2,
    input  logic [OP_W-1:0]  opcode,
    input  logic             opcode_valid,
    input  logic             branch_taken,
    input  logic             resume,
    output logic             halted,
    output logic             flush_detected,
    output logic             stall,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t          state, state_nx;
    logic [OP_W-1:0] cap_op, cap_op_nx;
    logic            cap_v, cap_v_nx;
    logic [3:0]      fcnt, fcnt_nx;
    logic            instr_inc;
    logic            flush_inc;

    always_comb begin
        state_nx  = state;
        cap_op_nx = cap_op;
        cap_v_nx  = cap_v;
        fcnt_nx   = fcnt;
        instr_inc = 1'b0;
        flush_inc = 1'b0;
        if (enable) begin
            case (state)
                RUN: begin
                    if (phase2) begin
                        cap_v_nx = 1'b0;
                        if (cap_v) begin
                            instr_inc = 1'b1;
                            if (cap_op == HLT_OPCODE) begin
                                state_nx = HALTED;
                            end else if (branch_taken) begin
                                state_nx  = FLUSH;
                                flush_inc = 1'b1;
                                fcnt_nx   = FLUSH_LOAD;
                            end
                        end
                    end
                    // phase1 loads after phase2 so a same-cycle capture survives
                    if (phase1) begin
                        cap_op_nx = opcode;
                        cap_v_nx  = opcode_valid;
                    end
                end
                FLUSH: begin
                    if (phase1) begin
                        cap_v_nx = 1'b0;
                    end
                    if (phase2) begin
                        if (fcnt <= 4'd1) begin
                            fcnt_nx  = 4'd0;
                            state_nx = RUN;
                        end else begin
                            fcnt_nx = fcnt - 4'd1;
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state_nx = RUN;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge internal_clock or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            cap_op         <= '0;
            cap_v          <= 1'b0;
            fcnt           <= 4'd0;
            halted         <= 1'b0;
            flush_detected <= 1'b0;
            stall          <= 1'b0;
            instr_count    <= '0;
        end else begin
            state          <= state_nx;
            cap_op         <= cap_op_nx;
            cap_v          <= cap_v_nx;
            fcnt           <= fcnt_nx;
            halted         <= (state_nx == HALTED);
            flush_detected <= (state_nx == FLUSH);
            stall          <= (state_nx != RUN);
            instr_count    <= instr_count + CNT_W'(instr_inc);
        end
    end

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (internal_clock),
        .rst   (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule
